tlb_unit: RTL and testbench

//  MIPS32-style joint TLB and translation unit, sitting directly beside CP0.

---
 rtl/translation_pkg.sv | 47 ++++
 rtl/tlb_lookup.sv | 53 +++++
 rtl/tlb_unit.sv | 162 ++++++++++++++++
 tb/tb_tlb_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/translation_pkg.sv
// Shared types for the joint TLB: entry layout, CP0 response bundle, op and FSM encodings.
// The TLBWR random-replacement feature is enabled by defining TLB_TLBWR_EN.
package translation_pkg;

   localparam int TLB_ENTRIES = 16;

   typedef enum logic [1:0] {
      OP_TLBP  = 2'b00,
      OP_TLBR  = 2'b01,
      OP_TLBWI = 2'b10,
      OP_TLBWR = 2'b11
   } tlb_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } tu_state_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      logic [19:0] pfn0;
      logic [2:0]  c0;
      logic        d0;
      logic        v0;
      logic [19:0] pfn1;
      logic [2:0]  c1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic [31:0] index;
      logic [31:0] entryhi;
      logic [31:0] entrylo0;
      logic [31:0] entrylo1;
   } tu_op_resp_t;

   // Rebuilds the CP0 EntryLo image of one page half; G is shared by both halves.
   function automatic logic [31:0] entry_lo(input logic [19:0] pfn, input logic [2:0] c,
                                            input logic d, input logic v, input logic g);
      return {6'b0, pfn, c, d, v, g};
   endfunction

endpackage

// File: rtl/tlb_lookup.sv
// Combinational TLB search: match on VPN2 and ASID/G, lowest index wins, odd/even page select.
import translation_pkg::*;

module tlb_lookup #(
   parameter int N     = 16,
   parameter int IDX_W = 4
) (
   input  tlb_entry_t        entries [N],
   input  logic [31:0]       vaddr,
   input  logic [7:0]        asid,
   output logic              hit,
   output logic [IDX_W-1:0]  hit_idx,
   output logic [31:0]       paddr,
   output logic              v,
   output logic              d
);

   tlb_entry_t sel;
   logic       unused_c;

   // Descending scan so the lowest matching index is the last one to assign.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (entries[i].vpn2 == vaddr[31:13] && (entries[i].g || entries[i].asid == asid)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      sel = entries[hit_idx];
      if (vaddr[12]) begin
         paddr = {sel.pfn1, vaddr[11:0]};
         v     = sel.v1;
         d     = sel.d1;
      end else begin
         paddr = {sel.pfn0, vaddr[11:0]};
         v     = sel.v0;
         d     = sel.d0;
      end
   end

   always_comb begin
      unused_c = 1'b0;
      for (int i = 0; i < N; i++) begin
         unused_c = unused_c ^ (^{entries[i].c0, entries[i].c1});
      end
   end

endmodule

// File: rtl/tlb_unit.sv
// MIPS32 joint TLB beside CP0: TLBP/TLBR/TLBWI/TLBWR sequencer plus fetch and data translation.
// Define TLB_TLBWR_EN for the free-running random counter used by TLBWR.
import translation_pkg::*;

module tlb_unit #(
   parameter int TLB_ENTRIES = translation_pkg::TLB_ENTRIES,
   parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         op_valid,
   output logic         op_ready,
   input  logic [1:0]   op,
   input  logic [31:0]  entryhi,
   input  logic [31:0]  entrylo0,
   input  logic [31:0]  entrylo1,
   input  logic [31:0]  index,
   output logic         resp_valid,
   output tu_op_resp_t  tu_op_resp,
   input  logic [31:0]  i_vaddr,
   output logic [31:0]  i_paddr,
   output logic         i_miss,
   output logic         i_invalid,
   input  logic [31:0]  d_vaddr,
   input  logic         d_write,
   output logic [31:0]  d_paddr,
   output logic         d_miss,
   output logic         d_invalid,
   output logic         d_modified,
   output tu_state_t    fsm_state
);

   // Handshake: a request transfers on the rising edge where op_valid && op_ready;
   // op_ready is high only in IDLE, and the request must be held until then.
   tu_state_t          state, state_d;
   tlb_entry_t         tlb [TLB_ENTRIES];
   tlb_op_t            op_q;
   logic [31:0]        hi_q, lo0_q, lo1_q;
   logic [IDX_W-1:0]   idx_q, wr_idx;
   logic               accept;
   tu_op_resp_t        resp_d;
   tlb_entry_t         wr_entry, rd_entry;
   logic               i_hit, i_v, i_d_unused;
   logic               d_hit, d_v, d_d;
   logic               p_hit, p_v_unused, p_d_unused;
   logic [IDX_W-1:0]   i_idx_unused, d_idx_unused, p_idx;
   logic [31:0]        p_paddr_unused;
   logic               unused_bits;

   always_comb begin
      state_d    = state;
      op_ready   = 1'b0;
      resp_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) state_d = ST_EXEC;
         end
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign accept    = op_valid && op_ready;
   assign fsm_state = state;

`ifdef TLB_TLBWR_EN
   logic [IDX_W-1:0] random_cnt, rand_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         random_cnt <= IDX_W'(TLB_ENTRIES - 1);
         rand_q     <= '0;
      end else begin
         random_cnt <= (random_cnt == '0) ? IDX_W'(TLB_ENTRIES - 1) : random_cnt - 1'b1;
         if (accept) rand_q <= random_cnt;
      end
   end

   assign wr_idx = (op_q == OP_TLBWR) ? rand_q : idx_q;
`else
   assign wr_idx = idx_q;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         op_q       <= OP_TLBP;
         hi_q       <= '0;
         lo0_q      <= '0;
         lo1_q      <= '0;
         idx_q      <= '0;
         tu_op_resp <= '0;
      end else begin
         state <= state_d;
         if (accept) begin
            op_q  <= tlb_op_t'(op);
            hi_q  <= entryhi;
            lo0_q <= entrylo0;
            lo1_q <= entrylo1;
            idx_q <= index[IDX_W-1:0];
         end
         if (state == ST_EXEC) tu_op_resp <= resp_d;
      end
   end

   assign wr_entry = '{vpn2: hi_q[31:13], asid: hi_q[7:0], g: lo0_q[0] & lo1_q[0],
                       pfn0: lo0_q[25:6], c0: lo0_q[5:3], d0: lo0_q[2], v0: lo0_q[1],
                       pfn1: lo1_q[25:6], c1: lo1_q[5:3], d1: lo1_q[2], v1: lo1_q[1]};

   // Both write ops have op[1] set; reset has priority so an aborted write never lands.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < TLB_ENTRIES; i++) tlb[i] <= '0;
      end else if (state == ST_EXEC && op_q[1]) begin
         tlb[wr_idx] <= wr_entry;
      end
   end

   assign rd_entry = tlb[idx_q];

   always_comb begin
      resp_d = '0;
      case (op_q)
         OP_TLBP: resp_d.index = p_hit ? 32'(p_idx) : 32'h8000_0000;
         OP_TLBR: begin
            resp_d.entryhi  = {rd_entry.vpn2, 5'b0, rd_entry.asid};
            resp_d.entrylo0 = entry_lo(rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g);
            resp_d.entrylo1 = entry_lo(rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g);
         end
         default: resp_d = '0;
      endcase
   end

   tlb_lookup #(.N(TLB_ENTRIES), .IDX_W(IDX_W)) u_fetch (
      .entries(tlb), .vaddr(i_vaddr), .asid(entryhi[7:0]),
      .hit(i_hit), .hit_idx(i_idx_unused), .paddr(i_paddr), .v(i_v), .d(i_d_unused)
   );

   tlb_lookup #(.N(TLB_ENTRIES), .IDX_W(IDX_W)) u_data (
      .entries(tlb), .vaddr(d_vaddr), .asid(entryhi[7:0]),
      .hit(d_hit), .hit_idx(d_idx_unused), .paddr(d_paddr), .v(d_v), .d(d_d)
   );

   tlb_lookup #(.N(TLB_ENTRIES), .IDX_W(IDX_W)) u_probe (
      .entries(tlb), .vaddr(hi_q), .asid(hi_q[7:0]),
      .hit(p_hit), .hit_idx(p_idx), .paddr(p_paddr_unused), .v(p_v_unused), .d(p_d_unused)
   );

   assign i_miss     = !i_hit;
   assign i_invalid  = i_hit && !i_v;
   assign d_miss     = !d_hit;
   assign d_invalid  = d_hit && !d_v;
   assign d_modified = d_hit && d_v && !d_d && d_write;

   assign unused_bits = ^{entryhi[12:8], index[31:IDX_W], hi_q[12:8], lo0_q[31:26], lo1_q[31:26]};

endmodule

// File: tb/tb_tlb_unit.sv
// Directed bench for tlb_unit: CP0 op sequencing, TLBP/TLBR results and fetch/data translation.
import translation_pkg::*;

module tb_tlb_unit;

   logic         clk = 1'b0;
   logic         resetn;
   logic         op_valid;
   logic         op_ready;
   logic [1:0]   op;
   logic [31:0]  entryhi, entrylo0, entrylo1, index;
   logic         resp_valid;
   tu_op_resp_t  tu_op_resp;
   logic [31:0]  i_vaddr, i_paddr;
   logic         i_miss, i_invalid;
   logic [31:0]  d_vaddr, d_paddr;
   logic         d_write, d_miss, d_invalid, d_modified;
   tu_state_t    fsm_state;

   int           n_checks = 0;
   int           n_fail   = 0;
   tu_op_resp_t  resp_got;
   logic [31:0]  exp_q[$];

   tlb_unit dut (
      .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready), .op(op),
      .entryhi(entryhi), .entrylo0(entrylo0), .entrylo1(entrylo1), .index(index),
      .resp_valid(resp_valid), .tu_op_resp(tu_op_resp),
      .i_vaddr(i_vaddr), .i_paddr(i_paddr), .i_miss(i_miss), .i_invalid(i_invalid),
      .d_vaddr(d_vaddr), .d_write(d_write), .d_paddr(d_paddr), .d_miss(d_miss),
      .d_invalid(d_invalid), .d_modified(d_modified), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // driver: one CP0 op, sampled on falling edges; hold keeps op_valid up through EXEC and RESP
   task automatic do_op(input logic [1:0] o, input logic [31:0] hi, input logic [31:0] lo0,
                        input logic [31:0] lo1, input logic [31:0] idx, input bit hold);
      @(negedge clk);
      op = o; entryhi = hi; entrylo0 = lo0; entrylo1 = lo1; index = idx;
      op_valid = 1'b1;
      @(negedge clk);
      check("exec_ready", 32'(op_ready), 32'd0);
      check("exec_resp", 32'(resp_valid), 32'd0);
      if (!hold) op_valid = 1'b0;
      @(negedge clk);
      check("resp_valid", 32'(resp_valid), 32'd1);
      resp_got = tu_op_resp;
      op_valid = 1'b0;
      @(negedge clk);
      check("resp_pulse", 32'(resp_valid), 32'd0);
      check("back_idle", 32'(fsm_state), 32'(ST_IDLE));
   endtask

   // scoreboard: TLBP expected index goes in, the observed response index comes out
   task automatic tlbp(input string tag, input logic [31:0] hi, input logic [31:0] exp_idx,
                       input bit hold);
      exp_q.push_back(exp_idx);
      do_op(2'b00, hi, 32'h0, 32'h0, 32'h0, hold);
      check(tag, resp_got.index, exp_q.pop_front());
      check({tag, "_hi"}, resp_got.entryhi, 32'h0);
   endtask

   initial begin
      resetn = 1'b0; op_valid = 1'b0; op = 2'b00;
      entryhi = '0; entrylo0 = '0; entrylo1 = '0; index = '0;
      i_vaddr = 32'h0040_0000; d_vaddr = '0; d_write = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(op_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_idx", tu_op_resp.index, 32'h0);
      check("rst_i_miss", 32'(i_miss), 32'd1);

      // empty TLB probe misses
      tlbp("probe_empty", 32'h0040_0000, 32'h8000_0000, 1'b0);

      // dual-page write at index 3, then data translation
      do_op(2'b10, 32'h0040_0005, 32'h0000_0486, 32'h0000_0D02, 32'd3, 1'b0);
      d_vaddr = 32'h0040_0ABC; d_write = 1'b0;
      @(negedge clk);
      check("d_even_paddr", d_paddr, 32'h0001_2ABC);
      check("d_even_miss", 32'(d_miss), 32'd0);
      d_write = 1'b1;
      @(negedge clk);
      check("d_even_mod", 32'(d_modified), 32'd0);
      d_vaddr = 32'h0040_1ABC;
      @(negedge clk);
      check("d_odd_paddr", d_paddr, 32'h0003_4ABC);
      check("d_odd_mod", 32'(d_modified), 32'd1);
      d_write = 1'b0;
      @(negedge clk);
      check("d_odd_mod_rd", 32'(d_modified), 32'd0);

      // read back entry 3
      do_op(2'b01, 32'h0040_0005, 32'h0, 32'h0, 32'd3, 1'b0);
      check("tlbr_hi", resp_got.entryhi, 32'h0040_0005);
      check("tlbr_lo0", resp_got.entrylo0, 32'h0000_0486);
      check("tlbr_lo1", resp_got.entrylo1, 32'h0000_0D02);
      check("tlbr_idx", resp_got.index, 32'h0);

      // ASID mismatch, then global rewrite
      entryhi = 32'h0040_0006; i_vaddr = 32'h0040_0000;
      @(negedge clk);
      check("asid_miss", 32'(i_miss), 32'd1);
      do_op(2'b10, 32'h0040_0005, 32'h0000_0487, 32'h0000_0D03, 32'd3, 1'b0);
      entryhi = 32'h0040_0006;
      @(negedge clk);
      check("global_hit", 32'(i_miss), 32'd0);
      check("global_paddr", i_paddr, 32'h0001_2000);

      // G only in lo0 is stored as non-global; TLBR reports G=0 in both halves
      do_op(2'b10, 32'h0080_2007, 32'h0000_0043, 32'h0000_0082, 32'd4, 1'b0);
      do_op(2'b01, 32'h0, 32'h0, 32'h0, 32'd4, 1'b0);
      check("partg_hi", resp_got.entryhi, 32'h0080_2007);
      check("partg_lo0", resp_got.entrylo0, 32'h0000_0042);
      check("partg_lo1", resp_got.entrylo1, 32'h0000_0082);

      // duplicate match at 2 and 5: lowest index wins everywhere
      do_op(2'b10, 32'h00A0_0009, 32'h0000_1542, 32'h0, 32'd5, 1'b0);
      do_op(2'b10, 32'h00A0_0009, 32'h0000_1982, 32'h0, 32'd2, 1'b0);
      tlbp("probe_dup", 32'h00A0_0009, 32'h0000_0002, 1'b1);
      d_vaddr = 32'h00A0_0123;
      @(negedge clk);
      check("dup_paddr", d_paddr, 32'h0006_6123);

      // match with V=0 reports invalid rather than miss
      do_op(2'b10, 32'h00C0_0009, 32'h0000_0400, 32'h0, 32'd6, 1'b0);
      i_vaddr = 32'h00C0_0010;
      @(negedge clk);
      check("inv_flag", 32'(i_invalid), 32'd1);
      check("inv_miss", 32'(i_miss), 32'd0);

`ifdef TLB_TLBWR_EN
      do_op(2'b11, 32'h00E0_0009, 32'h0000_0082, 32'h0, 32'd7, 1'b0);
      tlbp("probe_wr_unused", 32'h00C0_0009, 32'h0000_0006, 1'b0);
      do_op(2'b00, 32'h00E0_0009, 32'h0, 32'h0, 32'h0, 1'b0);
      check("tlbwr_hit", 32'(resp_got.index[31]), 32'd0);
`else
      do_op(2'b11, 32'h00E0_0009, 32'h0000_0082, 32'h0, 32'd7, 1'b0);
      tlbp("probe_wr_as_wi", 32'h00E0_0009, 32'h0000_0007, 1'b0);
`endif

      // reset during EXEC of a write aborts it
      @(negedge clk);
      op = 2'b10; entryhi = 32'h0100_0009; entrylo0 = 32'h0000_0082;
      entrylo1 = 32'h0; index = 32'd8; op_valid = 1'b1;
      @(negedge clk);
      check("abort_in_exec", 32'(fsm_state), 32'(ST_EXEC));
      op_valid = 1'b0; resetn = 1'b0;
      @(negedge clk);
      check("abort_resp", 32'(resp_valid), 32'd0);
      check("abort_state", 32'(fsm_state), 32'(ST_IDLE));
      resetn = 1'b1;
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
      d_vaddr = 32'h0100_0000;
      i_vaddr = 32'h00A0_0000;
      @(negedge clk);
      check("abort_no_write", 32'(d_miss), 32'd1);
      check("reset_clears", 32'(i_miss), 32'd1);
      check("abort_resp_zero", tu_op_resp.index, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
